fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the RISC-V core. It owns the program counter, drives the byte address into the combinational instruction memory, captures each returned 32-bit word together with its PC, and buffers the pair in a small FIFO. The FIFO presents the pair to the decode stage over a valid/ready handshake. Branch or jump redirects from downstream flush the buffer and reload the PC.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be 4-byte aligned.
- DEPTH, 2: FIFO entries; power of two, ≥ 2.
- clk  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high.
- fetch_en  in  1  fetch enable; when 0, no new fetches are enqueued and the PC holds.
- imem_addr  out  32  byte address to the instruction memory; always equals the internal PC register.
- imem_rdata  in  32  instruction word returned combinationally for imem_addr.
- redirect_valid  in  1  one-cycle request to flush the FIFO and load redirect_pc.
- redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 0.
- out_valid  out  1  head entry valid toward decode.
- out_ready  in  1  decode accepts the head entry.
- out_instr  out  32  head instruction word; 0 when out_valid=0.
- out_pc  out  32  PC of the head instruction; 0 when out_valid=0.

## Operation
- State consists of the PC register, a DEPTH-entry FIFO of {pc[31:0], instr[31:0]}, read/write pointers, and count (width $clog2(DEPTH)+1).
- out_valid = (count != 0) && !redirect_valid. This is combinational, so a redirect masks the head in the same cycle.
- pop = out_valid && out_ready.
- push = fetch_en && !redirect_valid && (count < DEPTH || pop).
  - A push writes {pc, imem_rdata} at the write pointer, and the PC advances by 4.
  - PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0.
- Redirect:
  - pc <= {redirect_pc[31:2], 2'b00}.
  - count, read pointer and write pointer are all set to 0.
  - No push and no pop occur in that cycle.
- Simultaneous push and pop (including when the FIFO is full): both take effect and count is unchanged.
- Full (count == DEPTH) with no pop: push is blocked, the PC holds, and imem_addr is stable.
- Empty: out_valid=0, out_instr=0, out_pc=0.
- The block does not decode instructions or check illegal opcodes.

## Timing
- Reset is sampled on the rising edge and dominates redirect_valid, fetch_en and out_ready.
- After the reset edge:
  - pc = RESET_PC and imem_addr = RESET_PC.
  - count = 0, out_valid = 0, out_instr = 0, out_pc = 0.
- Fetch latency is 1 cycle. The word at address A is presented on imem_addr in cycle N and appears on out_instr/out_pc in cycle N+1, provided it was pushed.
- With out_ready=1 and fetch_en=1, throughput is one instruction per cycle with no bubbles.
- The first valid output comes 1 cycle after reset deasserts.
- After a redirect cycle:
  - The next cycle fetches from the target with out_valid=0.
  - The target instruction is valid on the cycle after that, giving a 2-cycle redirect penalty.
- Reset asserted mid-stream clears everything at that edge. Entries already in the FIFO are lost and never presented.
- fetch_en deasserted does not flush. Buffered entries continue to drain through pop.

## Test plan
- Streaming:
  - Stimulus: memory loaded with 0x00411083, 0x00322423, 0x407302b3, … at byte addresses 0, 4, 8; out_ready=1; reset released.
  - Required: out_valid rises 1 cycle after reset deasserts; out_pc = 0, 4, 8, … on consecutive cycles with matching out_instr.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles after the first valid, DEPTH=2.
  - Required: count saturates at 2; imem_addr holds at 8; head stays pc=0, instr=0x00411083.
  - On release: outputs pc 0, 4, 8 with no gap and no duplicates.
- Redirect while full:
  - Stimulus: FIFO holds pc 0 and 4; pulse redirect_valid with redirect_pc=0x18.
  - Required: out_valid=0 during the pulse and the following cycle; the next cycle shows out_pc=0x18, out_instr=0x01180863. The flushed entries pc 0 and 4 never reappear.
- Misaligned redirect:
  - Stimulus: redirect_pc=0x1B.
  - Required: imem_addr=0x18 on the next cycle.
- Wrap:
  - Stimulus: RESET_PC=32'hFFFF_FFFC.
  - Required: out_pc sequence 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
- Reset mid-stream and fetch_en:
  - Stimulus: assert reset with 2 entries buffered.
  - Required: on the next cycle out_valid=0 and imem_addr=RESET_PC.
  - With fetch_en=0 after restart: out_valid stays 0 and imem_addr is constant.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage. Owns the program counter, drives the
//            byte address to a combinational instruction memory, captures the
//            returned word with its PC into a small FIFO and presents the head
//            entry to decode over a valid/ready handshake. A redirect flushes
//            the FIFO and reloads the PC.
// Ports    : clk_i            rising-edge clock
//            reset_i          synchronous, active-high reset
//            fetch_en_i       allow new fetches (PC holds when low)
//            imem_addr_o      byte address to instruction memory (= PC)
//            imem_rdata_i     instruction word for imem_addr_o
//            redirect_valid_i one-cycle flush + PC reload request
//            redirect_pc_i    redirect target (bits [1:0] ignored)
//            out_valid_o      head entry valid toward decode
//            out_ready_i      decode accepts head entry
//            out_instr_o      head instruction (0 when not valid)
//            out_pc_o         head PC (0 when not valid)
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        fetch_en_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_pc_o
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam int               CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      mem_pc_q    [DEPTH];
  logic [31:0]      mem_instr_q [DEPTH];

  logic        w_pop;
  logic        w_push;
  logic [31:0] w_redirect_tgt;

  // Masking with the redirect in the same cycle keeps a head entry that is
  // about to be flushed from ever being accepted by decode.
  assign out_valid_o    = (count_q != '0) && !redirect_valid_i;
  assign w_pop          = out_valid_o && out_ready_i;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_push         = fetch_en_i && !redirect_valid_i &&
                          ((count_q < C_DEPTH) || w_pop);
  assign w_redirect_tgt = redirect_pc_i & 32'hFFFF_FFFC;

  assign imem_addr_o = pc_q;
  assign out_instr_o = out_valid_o ? mem_instr_q[rd_ptr_q] : 32'h0;
  assign out_pc_o    = out_valid_o ? mem_pc_q[rd_ptr_q]    : 32'h0;

  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_valid_i) begin
      pc_d     = w_redirect_tgt;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk_i) begin
    if (!reset_i && w_push) begin
      mem_pc_q[wr_ptr_q]    <= pc_q;
      mem_instr_q[wr_ptr_q] <= imem_rdata_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed self-checking bench for fetch_unit: streaming,
//            backpressure, redirect while full, misaligned redirect, mid-stream
//            reset, fetch disable, and PC wrap-around on a second instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: RESET_PC = 0
  logic        reset_a, fetch_en_a, redir_a, ready_a;
  logic [31:0] redir_pc_a, addr_a, rdata_a, instr_a, pc_a;
  logic        valid_a;

  // Instance B: RESET_PC = 0xFFFF_FFFC
  logic        reset_b, fetch_en_b, redir_b, ready_b;
  logic [31:0] redir_pc_b, addr_b, rdata_b, instr_b, pc_b;
  logic        valid_b;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h00: mem_word = 32'h0041_1083;
      32'h04: mem_word = 32'h0032_2423;
      32'h08: mem_word = 32'h4073_02b3;
      32'h0C: mem_word = 32'h0000_0013;
      32'h10: mem_word = 32'h0010_0093;
      32'h14: mem_word = 32'h0020_0113;
      32'h18: mem_word = 32'h0118_0863;
      32'h1C: mem_word = 32'h0031_0193;
      default: mem_word = {a[15:0], 16'hA5A5};
    endcase
  endfunction

  assign rdata_a = mem_word(addr_a);
  assign rdata_b = mem_word(addr_b);

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk_i(clk), .reset_i(reset_a), .fetch_en_i(fetch_en_a),
    .imem_addr_o(addr_a), .imem_rdata_i(rdata_a),
    .redirect_valid_i(redir_a), .redirect_pc_i(redir_pc_a),
    .out_valid_o(valid_a), .out_ready_i(ready_a),
    .out_instr_o(instr_a), .out_pc_o(pc_a)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut_wrap (
    .clk_i(clk), .reset_i(reset_b), .fetch_en_i(fetch_en_b),
    .imem_addr_o(addr_b), .imem_rdata_i(rdata_b),
    .redirect_valid_i(redir_b), .redirect_pc_i(redir_pc_b),
    .out_valid_o(valid_b), .out_ready_i(ready_b),
    .out_instr_o(instr_b), .out_pc_o(pc_b)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are changed and outputs
  // sampled a couple of time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_head(input string tag, input logic [31:0] exp_pc);
    check({tag, ".valid"}, {31'h0, valid_a}, 32'h1);
    check({tag, ".pc"},    pc_a,             exp_pc);
    check({tag, ".instr"}, instr_a,          mem_word(exp_pc));
  endtask

  task automatic reset_a_seq(input logic rdy);
    reset_a = 1'b1; fetch_en_a = 1'b1; redir_a = 1'b0;
    redir_pc_a = 32'h0; ready_a = rdy;
    tick();
    reset_a = 1'b0;
    #1;
  endtask

  initial begin
    reset_a = 1'b1; fetch_en_a = 1'b1; redir_a = 1'b0; redir_pc_a = 32'h0;
    ready_a = 1'b1;
    reset_b = 1'b1; fetch_en_b = 1'b1; redir_b = 1'b0; redir_pc_b = 32'h0;
    ready_b = 1'b1;
    #2;

    // ---------------- Reset state + streaming ----------------
    tick();
    check("rst.addr",  addr_a,            32'h0);
    check("rst.valid", {31'h0, valid_a},  32'h0);
    check("rst.instr", instr_a,           32'h0);
    check("rst.pc",    pc_a,              32'h0);
    reset_a = 1'b0;
    #1;
    check("c0.valid", {31'h0, valid_a}, 32'h0);
    tick();
    check_head("s0", 32'h0);
    check("s0.addr", addr_a, 32'h4);
    tick(); check_head("s1", 32'h4);
    tick(); check_head("s2", 32'h8);
    tick(); check_head("s3", 32'hC);

    // ---------------- Backpressure ----------------
    reset_a_seq(1'b0);
    tick();                                     // first valid
    check_head("bp.first", 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_head("bp.hold", 32'h0);
      check("bp.addr",  addr_a, 32'h8);
      check("bp.count", 32'(dut.count_q), 32'd2);
    end
    ready_a = 1'b1;
    #1;
    check_head("bp.r0", 32'h0);
    tick(); check_head("bp.r1", 32'h4);
    tick(); check_head("bp.r2", 32'h8);
    tick(); check_head("bp.r3", 32'hC);

    // ---------------- Redirect while full ----------------
    reset_a_seq(1'b0);
    tick(); tick();                             // FIFO holds pc 0 and 4
    check("rf.count", 32'(dut.count_q), 32'd2);
    redir_a = 1'b1; redir_pc_a = 32'h18;
    #1;
    check("rf.pulse.valid", {31'h0, valid_a}, 32'h0);
    tick();
    redir_a = 1'b0;
    #1;
    check("rf.next.valid", {31'h0, valid_a}, 32'h0);
    check("rf.next.addr",  addr_a, 32'h18);
    tick();
    check_head("rf.tgt", 32'h18);
    check("rf.instr.lit", instr_a, 32'h0118_0863);
    ready_a = 1'b1;
    tick();
    check_head("rf.after", 32'h1C);

    // ---------------- Misaligned redirect ----------------
    redir_a = 1'b1; redir_pc_a = 32'h1B;
    tick();
    redir_a = 1'b0;
    #1;
    check("mis.addr",  addr_a, 32'h18);
    check("mis.valid", {31'h0, valid_a}, 32'h0);
    tick();
    check_head("mis.tgt", 32'h18);

    // ---------------- Reset mid-stream, then fetch_en = 0 ----------------
    reset_a_seq(1'b0);
    tick(); tick();
    check("mr.count", 32'(dut.count_q), 32'd2);
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0; fetch_en_a = 1'b0; ready_a = 1'b1;
    #1;
    check("mr.valid", {31'h0, valid_a}, 32'h0);
    check("mr.addr",  addr_a, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("fe0.valid", {31'h0, valid_a}, 32'h0);
      check("fe0.addr",  addr_a, 32'h0);
    end

    // ---------------- fetch_en = 0 drains without flushing ----------------
    fetch_en_a = 1'b1; ready_a = 1'b0;
    tick(); tick();                             // pc 0 and 4 buffered
    fetch_en_a = 1'b0;
    ready_a = 1'b1;
    #1;
    check_head("dr0", 32'h0);
    tick(); check_head("dr1", 32'h4);
    tick();
    check("dr.empty", {31'h0, valid_a}, 32'h0);
    check("dr.addr",  addr_a, 32'h8);

    // ---------------- PC wrap (instance B) ----------------
    reset_b = 1'b0;
    #1;
    check("wr.addr0", addr_b, 32'hFFFF_FFFC);
    tick();
    check("wr.pc0",    pc_b, 32'hFFFF_FFFC);
    check("wr.instr0", instr_b, mem_word(32'hFFFF_FFFC));
    check("wr.addr1",  addr_b, 32'h0);
    tick();
    check("wr.pc1",    pc_b, 32'h0);
    check("wr.instr1", instr_b, 32'h0041_1083);
    tick();
    check("wr.pc2",    pc_b, 32'h4);
    check("wr.valid2", {31'h0, valid_b}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
